boot_loader: RTL and testbench

BOOT_LOADER -- requirements
Module: boot_loader

---
 rtl/cpu_pkg.sv | 19 +
 rtl/byte_packer.sv | 30 +++
 rtl/boot_loader.sv | 139 +++++++++++++
 tb/tb_boot_loader.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared boot-loader types and constants: FSM state encoding and stream framing widths.
package cpu_pkg;

    localparam int unsigned HDR_BYTES = 4;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned BCNT_W    = $clog2(HDR_BYTES);
    localparam int unsigned CNT_W     = WORD_W + 1;

    typedef enum logic [2:0] {
        ST_LEN,
        ST_DATA,
        ST_WRITE,
        ST_CHECK,
        ST_DONE,
        ST_ERR
    } boot_state_e;

endpackage

// File: rtl/byte_packer.sv
// Assembles a little-endian 32-bit word from accepted bytes; flags the byte that completes it.
module byte_packer
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic [WORD_W-1:0] word_c,
    output logic              word_done_c
);

    logic [BCNT_W-1:0]        cnt;
    logic [WORD_W-BYTE_W-1:0] lo;

    // Earlier bytes shift down so byte 0 ends up in the least significant lane.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            lo  <= '0;
        end else if (byte_valid) begin
            cnt <= cnt + BCNT_W'(1);
            lo  <= {byte_data, lo[WORD_W-BYTE_W-1:BYTE_W]};
        end
    end

    assign word_c      = {byte_data, lo};
    assign word_done_c = byte_valid && (cnt == BCNT_W'(HDR_BYTES - 1));

endmodule

// File: rtl/boot_loader.sv
// Byte-stream boot loader: count header, N LE words written to memory, CPU held in reset until done.
// Optional trailing XOR checksum byte enabled by `define BOOT_LOADER_CHECKSUM_EN.
module boot_loader
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    localparam int unsigned       REM_W     = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  MAX_WORDS = CNT_W'(1) << ADDR_W;
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

    boot_state_e       state;
    logic              accept;
    logic [WORD_W-1:0] word_c;
    logic              word_done_c;
    logic [REM_W-1:0]  remaining;
    logic [ADDR_W-1:0] addr_ptr;
`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] csum;
`endif

    assign accept = in_valid & in_ready;

    byte_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .byte_valid  (accept),
        .byte_data   (in_data),
        .word_c      (word_c),
        .word_done_c (word_done_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_LEN;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= BASE;
            mem_wdata <= '0;
            cpu_rst   <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            remaining <= '0;
            addr_ptr  <= BASE;
`ifdef BOOT_LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
            case (state)
                ST_LEN: begin
                    in_ready <= 1'b1;
                    if (word_done_c) begin
                        if (word_c == '0) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                            state    <= ST_CHECK;
`else
                            state    <= ST_DONE;
                            in_ready <= 1'b0;
                            done     <= 1'b1;
                            cpu_rst  <= 1'b0;
`endif
                        end else if ({1'b0, word_c} > MAX_WORDS) begin
                            state    <= ST_ERR;
                            in_ready <= 1'b0;
                            err      <= 1'b1;
                        end else begin
                            state     <= ST_DATA;
                            remaining <= REM_W'(word_c);
                        end
                    end
                end
                ST_DATA: begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                    if (accept) csum <= csum ^ in_data;
`endif
                    if (word_done_c) begin
                        state     <= ST_WRITE;
                        in_ready  <= 1'b0;
                        mem_we    <= 1'b1;
                        mem_addr  <= addr_ptr;
                        mem_wdata <= word_c;
                        addr_ptr  <= addr_ptr + ADDR_W'(1);
                        remaining <= remaining - REM_W'(1);
                    end
                end
                ST_WRITE: begin
                    if (remaining != '0) begin
                        state    <= ST_DATA;
                        in_ready <= 1'b1;
                    end else begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                        state    <= ST_CHECK;
                        in_ready <= 1'b1;
`else
                        state    <= ST_DONE;
                        done     <= 1'b1;
                        cpu_rst  <= 1'b0;
`endif
                    end
                end
`ifdef BOOT_LOADER_CHECKSUM_EN
                // Single trailing byte must equal the XOR of every payload byte.
                ST_CHECK: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        if (in_data == csum) begin
                            state   <= ST_DONE;
                            done    <= 1'b1;
                            cpu_rst <= 1'b0;
                        end else begin
                            state <= ST_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Randomized self-checking bench for boot_loader against a stream-level reference model.
module tb_boot_loader;

    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned BASE_ADDR = 0;
    localparam int unsigned DEPTH     = 1 << ADDR_W;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_rst;
    logic              done;
    logic              err;

    int n_checks = 0;
    int n_errors = 0;
    int we_count = 0;

    boot_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (rst && mem_we) we_count++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [ADDR_W-1:0] exp_addr(input int w);
        return ADDR_W'((BASE_ADDR + w) % DEPTH);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, exp_addr(0));
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_cpu_rst", cpu_rst, 1);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        @(negedge clk);
        rst = 1'b1;
        check("ready_before_edge", in_ready, 0);
        @(negedge clk);
        check("ready_after_edge", in_ready, 1);
    endtask

    // Presents one byte after an idle gap; returns once the accepting edge has passed.
    task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
        int t = 0;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        ok = in_ready;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Builds the byte stream from the header and words, drives it, and checks every write and the outcome.
    task automatic run_load(input logic [31:0] cnt, input logic [31:0] words[$],
                            input int gap_max, input bit bad_csum, input int stop);
        logic [7:0] bytes[$];
        logic [7:0] cs;
        logic [31:0] wv;
        bit ok;
        bit exp_err;
        int we0;
        int exp_writes;
        cs = 8'h00;
        for (int k = 0; k < 4; k++) bytes.push_back(cnt[8*k +: 8]);
        exp_err = (cnt > DEPTH);
        if (!exp_err) begin
            foreach (words[w]) begin
                wv = words[w];
                for (int k = 0; k < 4; k++) begin
                    bytes.push_back(wv[8*k +: 8]);
                    cs = cs ^ wv[8*k +: 8];
                end
            end
        end
`ifdef BOOT_LOADER_CHECKSUM_EN
        if (!exp_err) begin
            bytes.push_back(cs ^ {7'd0, bad_csum});
            exp_err = bad_csum;
        end
`endif
        exp_writes = (cnt > DEPTH) ? 0 : int'(cnt);
        we0 = we_count;
        foreach (bytes[i]) begin
            if (stop >= 0 && i >= stop) return;
            send_byte(bytes[i], (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0, ok);
            check("byte_accepted", ok, 1);
            if (i >= 4 && cnt <= DEPTH && ((i - 4) % 4) == 3 && ((i - 4) / 4) < words.size()) begin
                check("mem_we", mem_we, 1);
                check("mem_addr", mem_addr, exp_addr((i - 4) / 4));
                check("mem_wdata", mem_wdata, words[(i - 4) / 4]);
            end
        end
        if (stop >= 0) return;
`ifndef BOOT_LOADER_CHECKSUM_EN
        if (cnt != 0 && cnt <= DEPTH) @(negedge clk);
`endif
        check("done", done, !exp_err);
        check("err", err, exp_err);
        check("cpu_rst", cpu_rst, exp_err);
        check("in_ready_end", in_ready, 0);
        check("mem_we_end", mem_we, 0);
        check("write_count", we_count - we0, exp_writes);
        repeat (3) @(negedge clk);
        check("sticky", {done, err, cpu_rst}, {!exp_err, exp_err, exp_err});
    endtask

    logic [31:0] none[$];
    logic [31:0] ws[$];
    int          nw;

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        do_reset();
        ws = '{32'h12345678, 32'hDEADBEEF};
        run_load(32'd2, ws, 0, 1'b0, -1);

        do_reset();
        run_load(32'd0, none, 0, 1'b0, -1);

        do_reset();
        run_load(32'h0000_0401, none, 0, 1'b0, -1);

        // Exactly 2^ADDR_W words is still a legal count.
        do_reset();
        run_load(32'h0000_0400, none, 0, 1'b0, 4);
        check("max_count_err", err, 0);
        check("max_count_ready", in_ready, 1);
        check("max_count_done", done, 0);

        do_reset();
        run_load(32'd2, ws, 4, 1'b0, -1);

        do_reset();
        run_load(32'd2, ws, 0, 1'b0, 6);
        do_reset();
        ws = '{$urandom()};
        run_load(32'd1, ws, 0, 1'b0, -1);

`ifdef BOOT_LOADER_CHECKSUM_EN
        do_reset();
        ws = '{32'h44332211};
        run_load(32'd1, ws, 0, 1'b0, -1);
        do_reset();
        run_load(32'd1, ws, 0, 1'b1, -1);
`endif

        repeat (12) begin
            do_reset();
            ws.delete();
            nw = int'($urandom_range(6, 1));
            for (int k = 0; k < nw; k++) ws.push_back($urandom());
            run_load(32'(nw), ws, int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
